odelay_tap_ctrl: RTL and testbench

Multi-channel tap controller for ODELAYE2 primitives in `VAR_LOAD` mode. A valid/ready command port accepts increment, decrement, load and sweep commands. The block turns them into correctly timed one-cycle CE/INC/LD strobes on the selected channel and keeps a shadow copy of every channel's tap count. It sits between test logic (buttons, UART, counters) and a bank of ODELAYE2 instances clocked from the same `clk`.

---
 rtl/odelay_tap_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_odelay_tap_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/odelay_tap_ctrl.sv
// ----------------------------------------------------------------------------
// odelay_tap_ctrl
//
// Tap controller for a bank of ODELAYE2 primitives used in VAR_LOAD mode.
// Commands (INC, DEC, LOAD, SWEEP) arrive on a valid/ready port. Each one
// becomes a single one-cycle CE/INC or LD strobe on the selected channel,
// followed by a settle gap. A shadow copy of every channel's tap count is
// kept by replaying the strobes that were actually driven.
//
// Build option:
//   ODELAY_SWEEP_EN  when defined, op 3 (SWEEP) walks the selected channel
//                    through all 32 taps with a dwell on each tap.
//                    sweep_abort and sweep_wrap are only live in that build.
//                    Without it, op 3 is accepted and dropped.
//
// Ports:
//   clk              ODELAYE2 control clock, rising edge
//   rst_n            asynchronous active-low reset
//   cmd_valid/ready  command handshake; ready is high only in IDLE
//   cmd_op           0=INC 1=DEC 2=LOAD 3=SWEEP
//   cmd_ch           target channel; out-of-range channels are dropped
//   cmd_tap          tap value for LOAD
//   sweep_abort      stops a running sweep (SETTLE/DWELL only)
//   dly_ce/inc/ld    per-channel ODELAYE2 control strobes
//   dly_cntvaluein   per-channel CNTVALUEIN, channel k at [5k+4:5k]
//   tap_value        per-channel shadow tap count, same packing
//   busy             strobe, settle or dwell in progress
//   sweep_wrap       one-cycle pulse when a sweep completes
// ----------------------------------------------------------------------------
module odelay_tap_ctrl #(
   parameter int CHANNELS      = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int DWELL_CYCLES  = 1024,
   localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [CH_W-1:0]       cmd_ch,
   input  logic [4:0]            cmd_tap,
   input  logic                  sweep_abort,
   output logic [CHANNELS-1:0]   dly_ce,
   output logic [CHANNELS-1:0]   dly_inc,
   output logic [CHANNELS-1:0]   dly_ld,
   output logic [5*CHANNELS-1:0] dly_cntvaluein,
   output logic [5*CHANNELS-1:0] tap_value,
   output logic                  busy,
   output logic                  sweep_wrap
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(CHANNELS);

   localparam logic [1:0] OP_INC   = 2'd0;
   localparam logic [1:0] OP_DEC   = 2'd1;
   localparam logic [1:0] OP_LOAD  = 2'd2;
   localparam logic [1:0] OP_SWEEP = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_SETTLE = 2'd2
`ifdef ODELAY_SWEEP_EN
      , ST_DWELL = 2'd3
`endif
   } state_t;

   // One-hot decode of a channel number onto the channel vector.
   function automatic logic [CHANNELS-1:0] ch_onehot(input logic [CH_W-1:0] ch);
      logic [CHANNELS-1:0] oh;
      oh = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         oh[k] = (ch == CH_W'(k));
      end
      return oh;
   endfunction

   // True when the channel number addresses an existing ODELAYE2.
   function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
      return ({1'b0, ch} < CH_LIM);
   endfunction

   // Shadow tap update mirroring what the primitive does with the strobes.
   function automatic logic [4:0] next_tap(input logic [4:0] tap,
                                           input logic       ce,
                                           input logic       inc,
                                           input logic       ld,
                                           input logic [4:0] cntin);
      logic [4:0] nt;
      if (ld) begin
         nt = cntin;
      end else if (ce && inc) begin
         nt = tap + 5'd1;
      end else if (ce) begin
         nt = tap - 5'd1;
      end else begin
         nt = tap;
      end
      return nt;
   endfunction

   state_t                  state_q, state_d;
   logic [SET_W-1:0]        settle_cnt_q, settle_cnt_d;
   logic [CHANNELS-1:0]     dly_ce_q, dly_ce_d;
   logic [CHANNELS-1:0]     dly_inc_q, dly_inc_d;
   logic [CHANNELS-1:0]     dly_ld_q, dly_ld_d;
   logic [5*CHANNELS-1:0]   cntvalue_q, cntvalue_d;
   logic [5*CHANNELS-1:0]   tap_q, tap_d;
   logic                    busy_q, busy_d;
   logic                    sweep_wrap_q, sweep_wrap_d;
   logic [CHANNELS-1:0]     cmd_oh_s;

`ifdef ODELAY_SWEEP_EN
   localparam int DWL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DWL_W-1:0] DWL_LOAD = DWL_W'(DWELL_CYCLES - 1);

   logic [CH_W-1:0]         ch_q, ch_d;
   logic                    sweep_q, sweep_d;
   logic [4:0]              step_q, step_d;
   logic [DWL_W-1:0]        dwell_cnt_q, dwell_cnt_d;
   logic [CHANNELS-1:0]     sweep_oh_s;

   assign sweep_oh_s = ch_onehot(ch_q);
`else
   // Sweep inputs have no function in this build.
   logic                    sweep_unused_s;
   assign sweep_unused_s = sweep_abort & (DWELL_CYCLES > 0);
`endif

   assign cmd_oh_s = ch_onehot(cmd_ch);

   // Next-state, command capture and strobe generation.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      cntvalue_d   = cntvalue_q;
      dly_ce_d     = '0;
      dly_inc_d    = '0;
      dly_ld_d     = '0;
      sweep_wrap_d = 1'b0;
`ifdef ODELAY_SWEEP_EN
      ch_d         = ch_q;
      sweep_d      = sweep_q;
      step_d       = step_q;
      dwell_cnt_d  = dwell_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef ODELAY_SWEEP_EN
            sweep_d = 1'b0;
            step_d  = 5'd0;
`endif
            // Out-of-range channels fall through: accepted, nothing happens.
            if (cmd_valid && ch_in_range(cmd_ch)) begin
               case (cmd_op)
                  OP_INC: begin
                     state_d   = ST_STROBE;
                     dly_ce_d  = cmd_oh_s;
                     dly_inc_d = cmd_oh_s;
                  end
                  OP_DEC: begin
                     state_d  = ST_STROBE;
                     dly_ce_d = cmd_oh_s;
                  end
                  OP_LOAD: begin
                     state_d  = ST_STROBE;
                     dly_ld_d = cmd_oh_s;
                     // CNTVALUEIN is captured here so it is stable under LD.
                     for (int k = 0; k < CHANNELS; k++) begin
                        if (cmd_oh_s[k]) begin
                           cntvalue_d[5*k +: 5] = cmd_tap;
                        end else begin
                           cntvalue_d[5*k +: 5] = cntvalue_q[5*k +: 5];
                        end
                     end
                  end
                  OP_SWEEP: begin
`ifdef ODELAY_SWEEP_EN
                     state_d   = ST_STROBE;
                     ch_d      = cmd_ch;
                     sweep_d   = 1'b1;
                     dly_ce_d  = cmd_oh_s;
                     dly_inc_d = cmd_oh_s;
`else
                     state_d = ST_IDLE;
`endif
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STROBE: begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SET_LOAD;
         end
         ST_SETTLE: begin
`ifdef ODELAY_SWEEP_EN
            if (sweep_abort) begin
               state_d = ST_IDLE;
            end else if (settle_cnt_q == '0) begin
               if (sweep_q) begin
                  state_d     = ST_DWELL;
                  dwell_cnt_d = DWL_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               settle_cnt_d = settle_cnt_q - SET_W'(1);
            end
`else
            if (settle_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               settle_cnt_d = settle_cnt_q - SET_W'(1);
            end
`endif
         end
`ifdef ODELAY_SWEEP_EN
         ST_DWELL: begin
            if (sweep_abort) begin
               state_d = ST_IDLE;
            end else if (dwell_cnt_q == '0) begin
               // 32 increments bring the tap all the way round to its start.
               if (step_q == 5'd31) begin
                  state_d      = ST_IDLE;
                  sweep_wrap_d = 1'b1;
               end else begin
                  state_d   = ST_STROBE;
                  step_d    = step_q + 5'd1;
                  dly_ce_d  = sweep_oh_s;
                  dly_inc_d = sweep_oh_s;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q - DWL_W'(1);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Shadow tap counts follow the strobes as they leave the block.
   always_comb begin
      tap_d = tap_q;
      for (int k = 0; k < CHANNELS; k++) begin
         tap_d[5*k +: 5] = next_tap(tap_q[5*k +: 5], dly_ce_q[k], dly_inc_q[k],
                                    dly_ld_q[k], cntvalue_q[5*k +: 5]);
      end
   end

   // Control state, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         dly_ce_q     <= '0;
         dly_inc_q    <= '0;
         dly_ld_q     <= '0;
         cntvalue_q   <= '0;
         tap_q        <= '0;
         busy_q       <= 1'b0;
         sweep_wrap_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         dly_ce_q     <= dly_ce_d;
         dly_inc_q    <= dly_inc_d;
         dly_ld_q     <= dly_ld_d;
         cntvalue_q   <= cntvalue_d;
         tap_q        <= tap_d;
         busy_q       <= busy_d;
         sweep_wrap_q <= sweep_wrap_d;
      end
   end

`ifdef ODELAY_SWEEP_EN
   // Sweep bookkeeping: channel, step number and dwell countdown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q        <= '0;
         sweep_q     <= 1'b0;
         step_q      <= 5'd0;
         dwell_cnt_q <= '0;
      end else begin
         ch_q        <= ch_d;
         sweep_q     <= sweep_d;
         step_q      <= step_d;
         dwell_cnt_q <= dwell_cnt_d;
      end
   end
`endif

   assign cmd_ready      = (state_q == ST_IDLE);
   assign dly_ce         = dly_ce_q;
   assign dly_inc        = dly_inc_q;
   assign dly_ld         = dly_ld_q;
   assign dly_cntvaluein = cntvalue_q;
   assign tap_value      = tap_q;
   assign busy           = busy_q;
`ifdef ODELAY_SWEEP_EN
   assign sweep_wrap     = sweep_wrap_q;
`else
   assign sweep_wrap     = 1'b0;
`endif

endmodule

// File: tb/tb_odelay_tap_ctrl.sv
// Bench for odelay_tap_ctrl: expected strobe/wrap events are queued with
// their expected sample time when a command is issued; a monitor pops and
// compares each event the DUT presents.
module tb_odelay_tap_ctrl;
   localparam int CHANNELS = 2;
   localparam int SETTLE   = 4;
   localparam int DWELL    = 8;
   localparam int CH_W     = 1;

   localparam logic [1:0] OP_INC   = 2'd0;
   localparam logic [1:0] OP_DEC   = 2'd1;
   localparam logic [1:0] OP_LOAD  = 2'd2;
   localparam logic [1:0] OP_SWEEP = 2'd3;

   logic                  clk;
   logic                  rst_n;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [CH_W-1:0]       cmd_ch;
   logic [4:0]            cmd_tap;
   logic                  sweep_abort;
   logic [CHANNELS-1:0]   dly_ce;
   logic [CHANNELS-1:0]   dly_inc;
   logic [CHANNELS-1:0]   dly_ld;
   logic [5*CHANNELS-1:0] dly_cntvaluein;
   logic [5*CHANNELS-1:0] tap_value;
   logic                  busy;
   logic                  sweep_wrap;

   typedef struct {
      logic [1:0] ce;
      logic [1:0] inc;
      logic [1:0] ld;
      logic [9:0] cntin;
      logic       wrap;
      longint     t;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp  = 0;
   int  n_fail = 0;

   odelay_tap_ctrl #(
      .CHANNELS(CHANNELS), .SETTLE_CYCLES(SETTLE), .DWELL_CYCLES(DWELL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_tap(cmd_tap),
      .sweep_abort(sweep_abort), .dly_ce(dly_ce), .dly_inc(dly_inc),
      .dly_ld(dly_ld), .dly_cntvaluein(dly_cntvaluein), .tap_value(tap_value),
      .busy(busy), .sweep_wrap(sweep_wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at t=%0t",
                  name, act, act, req, req, $time);
      end
   endtask

   task automatic push(input logic [1:0] ce, input logic [1:0] inc, input logic [1:0] ld,
                       input logic [9:0] cntin, input logic wrap, input longint t);
      ev_t e;
      e.ce = ce; e.inc = inc; e.ld = ld; e.cntin = cntin; e.wrap = wrap; e.t = t;
      exp_q.push_back(e);
   endtask

   // Issue one command; returns the time of the accepting clock edge.
   task automatic send(input logic [1:0] op, input int ch, input logic [4:0] tap,
                       output longint t_acc);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_ch    = CH_W'(ch);
      cmd_tap   = tap;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: cmd_ready still 0 after %0d cycles, required 1", n);
      end
      @(posedge clk);
      t_acc = $time;
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(cmd_ready && !busy && exp_q.size() == 0) && n < 6000);
      if (n >= 6000) begin
         n_cmp++;
         n_fail++;
         $display("FAIL idle_timeout: ready=%0b busy=%0b pending=%0d, required idle with none pending",
                  cmd_ready, busy, exp_q.size());
      end
   endtask

   // Monitor: every strobe or wrap the DUT shows must match the queue head.
   initial begin : monitor
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ((|dly_ce) || (|dly_ld) || sweep_wrap)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: t=%0t ce=%b inc=%b ld=%b wrap=%b, required no event",
                        $time, dly_ce, dly_inc, dly_ld, sweep_wrap);
            end else begin
               e = exp_q.pop_front();
               if (dly_ce !== e.ce || dly_inc !== e.inc || dly_ld !== e.ld ||
                   dly_cntvaluein !== e.cntin || sweep_wrap !== e.wrap || longint'($time) != e.t) begin
                  n_fail++;
                  $display("FAIL event: got t=%0t ce=%b inc=%b ld=%b cntin=%h wrap=%b, required t=%0d ce=%b inc=%b ld=%b cntin=%h wrap=%b",
                           $time, dly_ce, dly_inc, dly_ld, dly_cntvaluein, sweep_wrap,
                           e.t, e.ce, e.inc, e.ld, e.cntin, e.wrap);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      longint ta;
      longint tb;
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 2'd0;
      cmd_ch      = '0;
      cmd_tap     = 5'd0;
      sweep_abort = 1'b0;
      tb          = 0;
      repeat (3) @(negedge clk);
      chk("rst_ce",    32'(dly_ce), 32'd0);
      chk("rst_inc",   32'(dly_inc), 32'd0);
      chk("rst_ld",    32'(dly_ld), 32'd0);
      chk("rst_cntin", 32'(dly_cntvaluein), 32'd0);
      chk("rst_tap",   32'(tap_value), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_wrap",  32'(sweep_wrap), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Three increments on channel 1, back to back.
      for (int i = 0; i < 3; i++) begin
         send(OP_INC, 1, 5'd0, ta);
         push(2'b10, 2'b10, 2'b00, 10'h000, 1'b0, ta + 5);
         if (i > 0) chk("inc_spacing", 32'(ta - tb), 32'd60);
         tb = ta;
      end
      wait_idle();
      chk("tap1_after_3inc", 32'(tap_value[9:5]), 32'd3);
      chk("tap0_untouched",  32'(tap_value[4:0]), 32'd0);

      // LOAD 31 on channel 0 with busy/ready timing.
      send(OP_LOAD, 0, 5'd31, ta);
      push(2'b00, 2'b00, 2'b01, 10'h01F, 1'b0, ta + 5);
      @(negedge clk);
      chk("busy_strobe",  32'(busy), 32'd1);
      chk("ready_strobe", 32'(cmd_ready), 32'd0);
      repeat (SETTLE) @(negedge clk);
      chk("busy_last_settle",  32'(busy), 32'd1);
      chk("ready_last_settle", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("busy_after",  32'(busy), 32'd0);
      chk("ready_after", 32'(cmd_ready), 32'd1);
      chk("tap0_load31", 32'(tap_value[4:0]), 32'd31);

      // INC at 31 wraps to 0.
      send(OP_INC, 0, 5'd0, ta);
      push(2'b01, 2'b01, 2'b00, 10'h01F, 1'b0, ta + 5);
      wait_idle();
      chk("tap0_wrap_up", 32'(tap_value[4:0]), 32'd0);

      // DEC at 0 wraps to 31, INC level low.
      send(OP_DEC, 0, 5'd0, ta);
      push(2'b01, 2'b00, 2'b00, 10'h01F, 1'b0, ta + 5);
      wait_idle();
      chk("tap0_wrap_down", 32'(tap_value[4:0]), 32'd31);
      chk("tap1_kept",      32'(tap_value[9:5]), 32'd3);

      // LOAD 7 on channel 1; channel 0 CNTVALUEIN stays at 31.
      send(OP_LOAD, 1, 5'd7, ta);
      push(2'b00, 2'b00, 2'b10, 10'h0FF, 1'b0, ta + 5);
      wait_idle();
      chk("tap1_load7", 32'(tap_value[9:5]), 32'd7);

`ifdef ODELAY_SWEEP_EN
      // Full sweep on channel 1: 32 strobes 13 cycles apart, then wrap.
      send(OP_SWEEP, 1, 5'd0, ta);
      for (int i = 0; i < 32; i++) begin
         push(2'b10, 2'b10, 2'b00, 10'h0FF, 1'b0, ta + 5 + 130 * i);
      end
      push(2'b00, 2'b00, 2'b00, 10'h0FF, 1'b1, ta + 5 + 4160);
      wait_idle();
      chk("tap1_after_sweep", 32'(tap_value[9:5]), 32'd7);

      // Sweep on channel 0 from 0, aborted in the 5th dwell.
      send(OP_LOAD, 0, 5'd0, ta);
      push(2'b00, 2'b00, 2'b01, 10'h0E0, 1'b0, ta + 5);
      wait_idle();
      send(OP_SWEEP, 0, 5'd0, ta);
      for (int i = 0; i < 5; i++) begin
         push(2'b01, 2'b01, 2'b00, 10'h0E0, 1'b0, ta + 5 + 130 * i);
      end
      repeat (60) @(negedge clk);
      sweep_abort = 1'b1;
      @(negedge clk);
      sweep_abort = 1'b0;
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      chk("abort_busy",  32'(busy), 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_pending", 32'(exp_q.size()), 32'd0);
      chk("tap0_abort",    32'(tap_value[4:0]), 32'd5);
`else
      // Without sweep support op 3 is accepted and dropped.
      send(OP_SWEEP, 1, 5'd0, ta);
      @(negedge clk);
      chk("op3_ready", 32'(cmd_ready), 32'd1);
      chk("op3_busy",  32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      chk("op3_tap1", 32'(tap_value[9:5]), 32'd7);
`endif

      // Reset asserted during a strobe drops it without a clock edge.
      send(OP_INC, 1, 5'd0, ta);
      #1;
      chk("pre_rst_ce", 32'(dly_ce), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_ce",    32'(dly_ce), 32'd0);
      chk("async_rst_inc",   32'(dly_inc), 32'd0);
      chk("async_rst_tap",   32'(tap_value), 32'd0);
      chk("async_rst_cntin", 32'(dly_cntvaluein), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_busy",  32'(busy), 32'd0);

      repeat (5) @(negedge clk);
      chk("final_pending", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
